mem_read_serializer: RTL and testbench
======================================

# mem_read_serializer

- Parametrised successor to the single-byte BRAM-to-UART read controller.
- Fetches a programmable run of words from a block-RAM read port (port B); each word is DATA_W bits, a multiple of 8.
- Serialises each word into bytes and hands the bytes one at a time to the UART transmitter using its tx_start/tx_ongoing handshake.
- Sits between the master FSM, the result BRAM and the UART TX; runs while the master is in the READ state and flags completion with read_done.

## Interface
Parameters:
- DATA_W, 8: BRAM word width; must be a multiple of 8 (8..64).
- ADDR_W, 10: BRAM address width; memory depth is 2**ADDR_W.
- READ_LAT, 1: BRAM read latency in cycles, from enb to doutb valid (1..3).
- READ_STATE, 2'd1: master_state encoding that enables this block.

Ports:
- clk  in  1  system clock; everything runs on the rising edge.
- rst  in  1  synchronous, active-high reset.
- master_state  in  2  master FSM state.
- rd_base  in  ADDR_W  start address; sampled when a run starts.
- rd_len  in  ADDR_W+1  number of words in the run; sampled when a run starts. 0 means 2**ADDR_W. Values above 2**ADDR_W are clamped to 2**ADDR_W.
- doutb  in  DATA_W  BRAM read data.
- enb  out  1  BRAM read enable.
- addrb  out  ADDR_W  BRAM read address.
- tx_ongoing  in  1  UART busy flag.
- tx_start  out  1  one-cycle request to transmit byte_to_send.
- byte_to_send  out  8  byte being transmitted.
- status  out  8  one-hot current state.
- status_next  out  8  one-hot next state (combinational).
- read_done  out  1  run complete.

## Operation
State machine, one-hot bit order: IDLE[0], FETCH[1], WAIT_MEM[2], LOAD[3], SEND[4], WAIT_ACK[5], WAIT_FREE[6], DONE[7].
- IDLE: when master_state==READ_STATE, latch rd_base and clamped rd_len, then go to FETCH.
- FETCH: enb=1 and addrb=current address for exactly one cycle. Go to WAIT_MEM if READ_LAT>1, else to LOAD.
- WAIT_MEM: wait until READ_LAT cycles have elapsed since FETCH, then go to LOAD.
- LOAD: capture doutb into the shift register; byte index=0; go to SEND.
- SEND: tx_start=1 for this cycle only. byte_to_send carries the most significant unsent byte. Go to WAIT_ACK.
- WAIT_ACK: hold until tx_ongoing==1, then go to WAIT_FREE.
- WAIT_FREE: hold until tx_ongoing==0, then branch:
  - more bytes in the word: SEND;
  - more words in the run: address+1 (wraps from 2**ADDR_W-1 to 0), then FETCH;
  - otherwise: DONE.
- DONE: read_done=1. Stay until master_state!=READ_STATE, then go to IDLE.
- Abort: if master_state!=READ_STATE in any state other than IDLE or DONE, go to IDLE on the next edge.
  - No further tx_start or enb is issued.
  - read_done is not asserted.
  - A byte already accepted by the UART completes on its own.
- Word counter is ADDR_W+1 bits wide, so a full-depth run of 2**ADDR_W words does not overflow.

## Timing
- Reset values: enb=0, addrb=0, tx_start=0, byte_to_send=0, read_done=0, status=8'h01. status_next=8'h01 while master_state!=READ_STATE.
- Latency from READ_STATE being seen in IDLE to the first tx_start: 3+READ_LAT cycles (IDLE, FETCH, READ_LAT-1 WAIT_MEM cycles, LOAD, SEND).
- byte_to_send is registered. It is valid in the SEND cycle and stays stable until the next SEND.
- tx_start is never asserted while tx_ongoing==1.
- If tx_ongoing is already 1 in SEND, WAIT_ACK exits on the next cycle.
- read_done rises on the cycle after the final WAIT_FREE exit. It clears on the cycle after master_state leaves READ_STATE.
- addrb holds its last value outside FETCH. enb is 0 outside FETCH.

## Configuration
- MEM_READ_SERIALIZER_CHECKSUM_EN defined:
  - After the last data byte of the run, one extra byte is sent: the 8-bit modulo-256 sum of all data bytes in the run.
  - It uses the same SEND/WAIT_ACK/WAIT_FREE sequence, and DONE follows its WAIT_FREE.
  - The sum clears when a run starts.
  - An aborted run sends no checksum byte.
- Undefined: no checksum logic; DONE follows the last data byte.

## Test plan
- DATA_W=8, rd_base=0, rd_len=4, memory[i]=8'hF0+i, UART model busy for 7 cycles -> bytes F0,F1,F2,F3 in order; exactly 4 tx_start pulses; read_done high until master_state returns to 0.
- DATA_W=32, rd_len=2, words 32'hA1B2C3D4 and 32'h11223344 -> bytes A1,B2,C3,D4,11,22,33,44 MSB-first; enb pulses exactly twice.
- ADDR_W=4, rd_base=14, rd_len=4 -> addrb sequence 14,15,0,1.
- rd_len=0 with ADDR_W=4 -> 16 words sent. Also: master_state dropped to 0 during WAIT_FREE of word 2 -> IDLE next cycle, no further tx_start, read_done stays 0.
- READ_LAT=3, DATA_W=8 -> first tx_start exactly 6 cycles after IDLE sees READ_STATE; captured byte matches memory.
- Checksum build, bytes 8'h80,8'h90 -> third byte 8'h10; with the macro undefined, exactly 2 bytes are sent.

Source files
------------

// File: rtl/mem_read_serializer.sv
// mem_read_serializer: fetches a run of BRAM words and streams them MSB-first as bytes to a UART tx.
// Define MEM_READ_SERIALIZER_CHECKSUM_EN to append a modulo-256 sum byte after each completed run.
module mem_read_serializer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int READ_LAT = 1,
    parameter logic [1:0] READ_STATE = 2'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        master_state,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W:0]   rd_len,
    input  logic [DATA_W-1:0] doutb,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic              tx_ongoing,
    output logic              tx_start,
    output logic [7:0]        byte_to_send,
    output logic [7:0]        status,
    output logic [7:0]        status_next,
    output logic              read_done
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [7:0] {
        IDLE      = 8'h01,
        FETCH     = 8'h02,
        WAIT_MEM  = 8'h04,
        LOAD      = 8'h08,
        SEND      = 8'h10,
        WAIT_ACK  = 8'h20,
        WAIT_FREE = 8'h40,
        DONE      = 8'h80
    } state_t;

    state_t state, state_next;
    logic [ADDR_W:0] words_left;
    logic [DATA_W-1:0] shreg;
    logic [3:0] byte_idx;
    logic [1:0] lat_cnt;
    logic run, more_bytes, more_words, data_send, cs_pending;
    logic [7:0] data_byte, cs_val;
    logic [ADDR_W:0] len_clamped;

    assign run = master_state == READ_STATE;
    assign more_bytes = byte_idx != 4'(NB - 1);
    assign more_words = words_left != {{ADDR_W{1'b0}}, 1'b1};
    assign len_clamped = (rd_len == '0 || rd_len > DEPTH) ? DEPTH : rd_len;
    assign data_byte = state == LOAD ? doutb[DATA_W-1 -: 8] : shreg[DATA_W-1 -: 8];
    assign data_send = state_next == SEND && (state == LOAD || more_bytes);
    assign status = state;
    assign status_next = state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = run ? FETCH : IDLE;
            FETCH:     state_next = READ_LAT > 1 ? WAIT_MEM : LOAD;
            WAIT_MEM:  state_next = lat_cnt == 2'(READ_LAT - 1) ? LOAD : WAIT_MEM;
            LOAD:      state_next = SEND;
            SEND:      state_next = WAIT_ACK;
            WAIT_ACK:  state_next = tx_ongoing ? WAIT_FREE : WAIT_ACK;
            WAIT_FREE: state_next = tx_ongoing ? WAIT_FREE :
                                    more_bytes ? SEND : more_words ? FETCH : cs_pending ? SEND : DONE;
            DONE:      state_next = run ? DONE : IDLE;
            default:   state_next = IDLE;
        endcase
        // Losing READ mid-run abandons it without signalling completion.
        if (!run && state != IDLE && state != DONE) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            enb          <= 1'b0;
            addrb        <= '0;
            tx_start     <= 1'b0;
            byte_to_send <= '0;
            read_done    <= 1'b0;
            words_left   <= '0;
            shreg        <= '0;
            byte_idx     <= '0;
            lat_cnt      <= '0;
        end else begin
            state     <= state_next;
            enb       <= state_next == FETCH;
            tx_start  <= state_next == SEND;
            read_done <= state_next == DONE;
            if (state == IDLE && state_next == FETCH) begin
                addrb      <= rd_base;
                words_left <= len_clamped;
            end else if (state == WAIT_FREE && state_next == FETCH) begin
                addrb      <= addrb + 1'b1;
                words_left <= words_left - 1'b1;
            end
            lat_cnt <= state == FETCH ? 2'd1 : state == WAIT_MEM ? lat_cnt + 2'd1 : lat_cnt;
            if (state_next == SEND) byte_to_send <= data_send ? data_byte : cs_val;
            if (data_send) begin
                shreg    <= (state == LOAD ? doutb : shreg) << 8;
                byte_idx <= state == LOAD ? 4'd0 : byte_idx + 4'd1;
            end
        end
    end

`ifdef MEM_READ_SERIALIZER_CHECKSUM_EN
    logic [7:0] sum;
    logic cs_phase;

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            sum      <= '0;
            cs_phase <= 1'b0;
        end else if (data_send) begin
            sum <= sum + data_byte;
        end else if (state_next == SEND) begin
            cs_phase <= 1'b1;
        end
    end

    assign cs_pending = !cs_phase;
    assign cs_val = sum;
`else
    assign cs_pending = 1'b0;
    assign cs_val = 8'h00;
`endif
endmodule

// File: tb/tb_mem_read_serializer.sv
// tb_mem_read_serializer: two serializers (32-bit/latency 1 and 8-bit/latency 3) on 16-word memories,
// each driven by a UART model that stays busy 7 cycles per byte, checked against a byte-list model.
module tb_mem_read_serializer;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] master_state;
    logic [3:0] rd_base;
    logic [4:0] rd_len;
    always #5 clk = ~clk;

    logic [31:0] mem_a [16];
    logic [31:0] dout_a;
    logic enb_a, tx_start_a, tx_ongoing_a, read_done_a;
    logic [3:0] addrb_a;
    logic [7:0] byte_a, status_a, status_next_a;

    logic [7:0] mem_b [16];
    logic [7:0] d1_b, d2_b, dout_b;
    logic enb_b, tx_start_b, tx_ongoing_b, read_done_b;
    logic [3:0] addrb_b;
    logic [7:0] byte_b, status_b, status_next_b;

    mem_read_serializer #(.DATA_W(32), .ADDR_W(4), .READ_LAT(1), .READ_STATE(2'd1)) u_a (
        .clk(clk), .rst(rst), .master_state(master_state), .rd_base(rd_base), .rd_len(rd_len),
        .doutb(dout_a), .enb(enb_a), .addrb(addrb_a), .tx_ongoing(tx_ongoing_a),
        .tx_start(tx_start_a), .byte_to_send(byte_a), .status(status_a),
        .status_next(status_next_a), .read_done(read_done_a));

    mem_read_serializer #(.DATA_W(8), .ADDR_W(4), .READ_LAT(3), .READ_STATE(2'd1)) u_b (
        .clk(clk), .rst(rst), .master_state(master_state), .rd_base(rd_base), .rd_len(rd_len),
        .doutb(dout_b), .enb(enb_b), .addrb(addrb_b), .tx_ongoing(tx_ongoing_b),
        .tx_start(tx_start_b), .byte_to_send(byte_b), .status(status_b),
        .status_next(status_next_b), .read_done(read_done_b));

    int busy_a, busy_b;
    always @(posedge clk) begin
        if (enb_a) dout_a <= mem_a[addrb_a];
        d1_b <= mem_b[addrb_b];
        d2_b <= d1_b;
        dout_b <= d2_b;
        busy_a <= rst ? 0 : tx_start_a ? 7 : busy_a > 0 ? busy_a - 1 : 0;
        busy_b <= rst ? 0 : tx_start_b ? 7 : busy_b > 0 ? busy_b - 1 : 0;
    end
    assign tx_ongoing_a = busy_a != 0;
    assign tx_ongoing_b = busy_b != 0;

    logic [7:0] q_a[$], q_b[$];
    logic [3:0] ad_a[$], ad_b[$];
    int viol_a = 0, viol_b = 0;
    always @(negedge clk) begin
        if (tx_start_a) q_a.push_back(byte_a);
        if (tx_start_b) q_b.push_back(byte_b);
        if (enb_a) ad_a.push_back(addrb_a);
        if (enb_b) ad_b.push_back(addrb_b);
        if (tx_start_a && tx_ongoing_a) viol_a++;
        if (tx_start_b && tx_ongoing_b) viol_b++;
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [3:0] base, input logic [4:0] len);
        int sa = q_a.size(), sb = q_b.size(), aa = ad_a.size(), ab = ad_b.size();
        int n = (len == 0 || len > 16) ? 16 : int'(len);
        int lat_a = 0, lat_b = 0;
        logic [7:0] exp_a[$], exp_b[$], ca = 0, cb = 0;
        logic [3:0] exp_ad[$], ad;
        for (int w = 0; w < n; w++) begin
            ad = base + 4'(w);
            exp_ad.push_back(ad);
            for (int k = 3; k >= 0; k--) begin
                exp_a.push_back(mem_a[ad][8*k +: 8]);
                ca += mem_a[ad][8*k +: 8];
            end
            exp_b.push_back(mem_b[ad]);
            cb += mem_b[ad];
        end
`ifdef MEM_READ_SERIALIZER_CHECKSUM_EN
        exp_a.push_back(ca);
        exp_b.push_back(cb);
`endif
        rd_base = base;
        rd_len = len;
        master_state = 2'd1;
        for (int k = 2; k <= 40 && (lat_a == 0 || lat_b == 0); k++) begin
            @(negedge clk);
            if (tx_start_a && lat_a == 0) lat_a = k;
            if (tx_start_b && lat_b == 0) lat_b = k;
        end
        chk("latency_a", 32'(lat_a), 32'd4);
        chk("latency_b", 32'(lat_b), 32'd6);
        for (int c = 0; c < 3000 && !(read_done_a && read_done_b); c++) @(negedge clk);
        chk("done_a", 32'(read_done_a), 32'd1);
        chk("done_b", 32'(read_done_b), 32'd1);
        chk("nbytes_a", 32'(q_a.size() - sa), 32'(exp_a.size()));
        chk("nbytes_b", 32'(q_b.size() - sb), 32'(exp_b.size()));
        foreach (exp_a[i]) if (sa + i < q_a.size()) chk($sformatf("byte_a[%0d]", i), 32'(q_a[sa+i]), 32'(exp_a[i]));
        foreach (exp_b[i]) if (sb + i < q_b.size()) chk($sformatf("byte_b[%0d]", i), 32'(q_b[sb+i]), 32'(exp_b[i]));
        chk("nenb_a", 32'(ad_a.size() - aa), 32'(n));
        chk("nenb_b", 32'(ad_b.size() - ab), 32'(n));
        foreach (exp_ad[i]) begin
            if (aa + i < ad_a.size()) chk($sformatf("addr_a[%0d]", i), 32'(ad_a[aa+i]), 32'(exp_ad[i]));
            if (ab + i < ad_b.size()) chk($sformatf("addr_b[%0d]", i), 32'(ad_b[ab+i]), 32'(exp_ad[i]));
        end
        repeat (3) @(negedge clk);
        chk("done_hold_a", 32'(read_done_a), 32'd1);
        chk("done_hold_b", 32'(read_done_b), 32'd1);
        master_state = 2'd0;
        @(negedge clk);
        chk("done_clr_a", 32'(read_done_a), 32'd0);
        chk("done_clr_b", 32'(read_done_b), 32'd0);
        chk("idle_a", 32'(status_a), 32'h01);
        chk("idle_next_b", 32'(status_next_b), 32'h01);
        @(negedge clk);
    endtask

    initial begin
        int sa;
        rst = 1'b1;
        master_state = 2'd0;
        rd_base = '0;
        rd_len = '0;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = 8'($urandom);
        end
        for (int i = 0; i < 4; i++) mem_b[i] = 8'hF0 + 8'(i);
        mem_a[0] = 32'hA1B2C3D4;
        mem_a[1] = 32'h11223344;
        repeat (3) @(negedge clk);
        chk("rst_enb", 32'(enb_a), 32'd0);
        chk("rst_addrb", 32'(addrb_a), 32'd0);
        chk("rst_tx_start", 32'(tx_start_a), 32'd0);
        chk("rst_byte", 32'(byte_a), 32'd0);
        chk("rst_done", 32'(read_done_b), 32'd0);
        chk("rst_status", 32'(status_b), 32'h01);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_next", 32'(status_next_a), 32'h01);
        run(4'd0, 5'd4);
        run(4'd14, 5'd4);
        run(4'd0, 5'd0);
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = 8'($urandom);
        end
        run(4'($urandom), 5'($urandom_range(17, 31)));
        run(4'($urandom), 5'($urandom_range(1, 16)));
        // Abort while word 2 of the 32-bit instance drains its last byte.
        sa = q_a.size();
        rd_base = 4'd3;
        rd_len = 5'd4;
        master_state = 2'd1;
        for (int c = 0; c < 2000 && !(status_a == 8'h40 && q_a.size() - sa >= 8); c++) @(negedge clk);
        chk("abort_reach", 32'(status_a), 32'h40);
        master_state = 2'd0;
        @(negedge clk);
        chk("abort_idle_a", 32'(status_a), 32'h01);
        chk("abort_idle_b", 32'(status_b), 32'h01);
        repeat (40) @(negedge clk);
        chk("abort_nbytes", 32'(q_a.size() - sa), 32'd8);
        for (int i = 0; i < 8; i++)
            if (sa + i < q_a.size()) chk($sformatf("abort_byte[%0d]", i), 32'(q_a[sa+i]), 32'(mem_a[3 + i/4][8*(3 - i%4) +: 8]));
        chk("abort_done_a", 32'(read_done_a), 32'd0);
        chk("abort_done_b", 32'(read_done_b), 32'd0);
        chk("start_while_busy_a", 32'(viol_a), 32'd0);
        chk("start_while_busy_b", 32'(viol_b), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
